// File: rtl/calc_pkg.sv
// Shared constants and types for the calc port scoreboard: resp/cmd codes,
// expectation packet layout and failure causes.
package calc_pkg;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  localparam logic [3:0] ADD = 4'd1;
  localparam logic [3:0] SUB = 4'd2;
  localparam logic [3:0] SHL = 4'd5;
  localparam logic [3:0] SHR = 4'd6;

  localparam int EXP_W         = 37;
  localparam int EXP_TAG_HI    = 36;
  localparam int EXP_TAG_LO    = 35;
  localparam int EXP_RESP_HI   = 34;
  localparam int EXP_RESP_LO   = 33;
  localparam int EXP_RESULT_HI = 32;
  localparam int EXP_RESULT_LO = 1;
  localparam int EXP_FLAG      = 0;

  localparam int NUM_TAGS = 4;

  typedef struct packed {
    logic [1:0]  tag;
    logic [1:0]  resp;
    logic [31:0] result;
    logic        flag;
  } exp_pkt_t;

  typedef enum logic [2:0] {
    FC_NONE    = 3'd0,
    FC_RESP    = 3'd1,
    FC_DATA    = 3'd2,
    FC_UNEXP   = 3'd3,
    FC_DUP     = 3'd4,
    FC_TIMEOUT = 3'd5
  } fail_code_t;

endpackage

// File: rtl/calc_sb_entry.sv
// One scoreboard slot: valid, expected resp/result and an age counter that
// flags expiry when it reaches TIMEOUT-1; set wins over clear, no backpressure.
module calc_sb_entry
  import calc_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        c_clk,
  input  logic        reset_n,
  input  logic        set,
  input  logic        clr,
  input  logic [1:0]  set_resp,
  input  logic [31:0] set_result,
  output logic        valid,
  output logic [1:0]  exp_resp,
  output logic [31:0] exp_result,
  output logic        expire
);

  localparam int AGE_W = $clog2(TIMEOUT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT - 1);
  localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);

  logic [AGE_W-1:0] age;

  assign expire = valid && (age == AGE_MAX);

  // A same-cycle set replaces a retiring entry, so it takes priority over clr.
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      valid      <= 1'b0;
      age        <= '0;
      exp_resp   <= RESP_NONE;
      exp_result <= '0;
    end else if (set) begin
      valid      <= 1'b1;
      age        <= '0;
      exp_resp   <= set_resp;
      exp_result <= set_result;
    end else if (clr) begin
      valid <= 1'b0;
      age   <= '0;
    end else if (valid) begin
      age <= age + AGE_ONE;
    end
  end

endmodule

// File: rtl/calc_port_scoreboard.sv
// Tag-indexed scoreboard matching golden expectations against DUT port responses;
// pulses/fail_code registered with 1-cycle latency, never stalls either side.
module calc_port_scoreboard
  import calc_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             c_clk,
  input  logic             reset_n,
  input  logic             exp_valid,
  input  logic [EXP_W-1:0] exp_packet,
  input  logic [1:0]       out_resp,
  input  logic [1:0]       out_tag,
  input  logic [31:0]      out_data,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output logic [2:0]       fail_code,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [2:0]       outstanding,
  output logic             idle
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]  exp_tag;
  logic [1:0]  exp_resp;
  logic [31:0] exp_result;
  logic        unused_flag;

  assign exp_tag     = exp_packet[EXP_TAG_HI:EXP_TAG_LO];
  assign exp_resp    = exp_packet[EXP_RESP_HI:EXP_RESP_LO];
  assign exp_result  = exp_packet[EXP_RESULT_HI:EXP_RESULT_LO];
  assign unused_flag = exp_packet[EXP_FLAG];

  logic [NUM_TAGS-1:0] ent_valid;
  logic [NUM_TAGS-1:0] ent_expire;
  logic [NUM_TAGS-1:0] ent_set;
  logic [NUM_TAGS-1:0] ent_clr;
  logic [NUM_TAGS-1:0] retire;
  logic [NUM_TAGS-1:0] timeout;
  logic [1:0]          ent_resp   [NUM_TAGS];
  logic [31:0]         ent_result [NUM_TAGS];

  for (genvar i = 0; i < NUM_TAGS; i++) begin : g_entry
    calc_sb_entry #(.TIMEOUT(TIMEOUT)) u_entry (
      .c_clk      (c_clk),
      .reset_n    (reset_n),
      .set        (ent_set[i]),
      .clr        (ent_clr[i]),
      .set_resp   (exp_resp),
      .set_result (exp_result),
      .valid      (ent_valid[i]),
      .exp_resp   (ent_resp[i]),
      .exp_result (ent_result[i]),
      .expire     (ent_expire[i])
    );
  end

  logic           resp_vld;
  logic           tag_hit;
  logic           unexpected;
  logic           resp_mis;
  logic           data_mis;
  logic           match;
  logic           exp_in;
  logic           slot_busy;
  logic           dup;
  logic [2:0]     n_fail;
  fail_code_t     code_nxt;
  fail_code_t     fail_code_q;
  logic [CNT_W:0] fail_sum;
  logic [2:0]     valid_cnt;

  always_comb begin
    resp_vld   = (out_resp != RESP_NONE);
    tag_hit    = ent_valid[out_tag];
    unexpected = resp_vld && !tag_hit;
    resp_mis   = resp_vld && tag_hit && (out_resp != ent_resp[out_tag]);
    data_mis   = resp_vld && tag_hit && !resp_mis && (ent_resp[out_tag] == RESP_OK) &&
                 (out_data != ent_result[out_tag]);
    match      = resp_vld && tag_hit && !resp_mis && !data_mis;
    exp_in     = exp_valid && (exp_resp != RESP_NONE);

    retire = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      retire[i] = resp_vld && tag_hit && (out_tag == 2'(i));
    end
    // A response arriving on the expiry cycle still gets compared, not timed out.
    timeout = ent_expire & ~retire;
    ent_clr = retire | timeout;

    // The response is judged against the old entry, so a freed slot accepts the new one.
    slot_busy = ent_valid[exp_tag] && !ent_clr[exp_tag];
    dup       = exp_in && slot_busy;
    ent_set   = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      ent_set[i] = exp_in && !slot_busy && (exp_tag == 2'(i));
    end

    n_fail = 3'(dup) + 3'(unexpected | resp_mis | data_mis);
    for (int i = 0; i < NUM_TAGS; i++) begin
      n_fail = n_fail + 3'(timeout[i]);
    end

    code_nxt = FC_NONE;
    if (timeout != '0)    code_nxt = FC_TIMEOUT;
    else if (dup)         code_nxt = FC_DUP;
    else if (unexpected)  code_nxt = FC_UNEXP;
    else if (data_mis)    code_nxt = FC_DATA;
    else if (resp_mis)    code_nxt = FC_RESP;

    fail_sum = {1'b0, fail_cnt} + (CNT_W+1)'(n_fail);

    valid_cnt = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      valid_cnt = valid_cnt + 3'(ent_valid[i]);
    end
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      pass_pulse  <= 1'b0;
      fail_pulse  <= 1'b0;
      fail_code_q <= FC_NONE;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
    end else begin
      pass_pulse <= match;
      fail_pulse <= (n_fail != 3'd0);
      if (n_fail != 3'd0) fail_code_q <= code_nxt;
      if (match && (pass_cnt != '1)) pass_cnt <= pass_cnt + CNT_ONE;
      fail_cnt <= fail_sum[CNT_W] ? '1 : fail_sum[CNT_W-1:0];
    end
  end

  assign fail_code   = fail_code_q;
  assign outstanding = valid_cnt;
  assign idle        = (valid_cnt == 3'd0);

endmodule

// File: tb/tb_calc_port_scoreboard.sv
// Directed bench for calc_port_scoreboard; narrow counters expose saturation.
module tb_calc_port_scoreboard;
  import calc_pkg::*;

  localparam int CNT_W = 3;

  logic             c_clk = 1'b0;
  logic             reset_n;
  logic             exp_valid;
  logic [EXP_W-1:0] exp_packet;
  logic [1:0]       out_resp;
  logic [1:0]       out_tag;
  logic [31:0]      out_data;
  logic             pass_pulse;
  logic             fail_pulse;
  logic [2:0]       fail_code;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [2:0]       outstanding;
  logic             idle;

  int checks   = 0;
  int failures = 0;

  always #5 c_clk = ~c_clk;

  calc_port_scoreboard #(.TIMEOUT(64), .CNT_W(CNT_W)) dut (
    .c_clk       (c_clk),
    .reset_n     (reset_n),
    .exp_valid   (exp_valid),
    .exp_packet  (exp_packet),
    .out_resp    (out_resp),
    .out_tag     (out_tag),
    .out_data    (out_data),
    .pass_pulse  (pass_pulse),
    .fail_pulse  (fail_pulse),
    .fail_code   (fail_code),
    .pass_cnt    (pass_cnt),
    .fail_cnt    (fail_cnt),
    .outstanding (outstanding),
    .idle        (idle)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  task automatic set_exp(input logic [1:0] tag, input logic [1:0] resp, input logic [31:0] result);
    exp_pkt_t p;
    p.tag    = tag;
    p.resp   = resp;
    p.result = result;
    p.flag   = 1'b0;
    exp_valid  = 1'b1;
    exp_packet = p;
  endtask

  task automatic set_rsp(input logic [1:0] resp, input logic [1:0] tag, input logic [31:0] data);
    out_resp = resp;
    out_tag  = tag;
    out_data = data;
  endtask

  task automatic clr_in();
    exp_valid  = 1'b0;
    exp_packet = '0;
    out_resp   = RESP_NONE;
    out_tag    = 2'd0;
    out_data   = 32'd0;
  endtask

  initial begin
    reset_n = 1'b0;
    clr_in();
    #12;
    chk("rst_pass_pulse", pass_pulse, 0);
    chk("rst_fail_pulse", fail_pulse, 0);
    chk("rst_fail_code", fail_code, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_idle", idle, 1);
    reset_n = 1'b1;
    step();

    // basic match, response 5 cycles after the expectation
    set_exp(2'd1, RESP_OK, 32'h0000_0003);
    step(); clr_in();
    chk("s1_outstanding", outstanding, 1);
    chk("s1_idle", idle, 0);
    chk("s1_no_early_pass", pass_pulse, 0);
    repeat (4) step();
    set_rsp(RESP_OK, 2'd1, 32'd3);
    step(); clr_in();
    chk("s1_pass_pulse", pass_pulse, 1);
    chk("s1_fail_pulse", fail_pulse, 0);
    chk("s1_pass_cnt", pass_cnt, 1);
    chk("s1_outstanding_end", outstanding, 0);
    step();
    chk("s1_pulse_one_cycle", pass_pulse, 0);

    // data mismatch
    set_exp(2'd2, RESP_OK, 32'h0000_0010);
    step(); clr_in();
    set_rsp(RESP_OK, 2'd2, 32'h0000_0011);
    step(); clr_in();
    chk("s2_fail_pulse", fail_pulse, 1);
    chk("s2_fail_code", fail_code, 2);
    chk("s2_fail_cnt", fail_cnt, 1);
    chk("s2_pass_pulse", pass_pulse, 0);

    // resp mismatch
    set_exp(2'd3, RESP_OK, 32'h0000_0005);
    step(); clr_in();
    set_rsp(RESP_ERR, 2'd3, 32'h0000_0005);
    step(); clr_in();
    chk("s2b_fail_code", fail_code, 1);
    chk("s2b_fail_cnt", fail_cnt, 2);

    // SUB underflow: error response, data ignored
    set_exp(2'd0, RESP_ERR, 32'h0000_0000);
    step(); clr_in();
    set_rsp(RESP_ERR, 2'd0, 32'hFFFF_FFFF);
    step(); clr_in();
    chk("s3_pass_pulse", pass_pulse, 1);
    chk("s3_pass_cnt", pass_cnt, 2);
    chk("s3_fail_cnt", fail_cnt, 2);

    // expectation with resp 0 is ignored
    set_exp(2'd2, RESP_NONE, 32'h1234_5678);
    step(); clr_in();
    chk("ign_outstanding", outstanding, 0);
    chk("ign_fail_pulse", fail_pulse, 0);

    // fill all four tags, then duplicate tag 3
    for (int i = 0; i < 4; i++) begin
      set_exp(2'(i), RESP_OK, 32'h100 + 32'(i));
      step(); clr_in();
    end
    chk("s4_full", outstanding, 4);
    set_exp(2'd3, RESP_OK, 32'h0000_DEAD);
    step(); clr_in();
    chk("s4_dup_pulse", fail_pulse, 1);
    chk("s4_dup_code", fail_code, 4);
    chk("s4_dup_cnt", fail_cnt, 3);
    chk("s4_dup_outstanding", outstanding, 4);
    set_rsp(RESP_OK, 2'd3, 32'h0000_0103);
    step(); clr_in();
    chk("s4_orig_kept", pass_pulse, 1);
    chk("s4_pass_cnt", pass_cnt, 3);
    chk("s4_outstanding3", outstanding, 3);
    for (int i = 0; i < 3; i++) begin
      set_rsp(RESP_OK, 2'(i), 32'h100 + 32'(i));
      step(); clr_in();
    end
    chk("s4_drain_pass_cnt", pass_cnt, 6);
    chk("s4_drain_idle", idle, 1);

    // duplicate and unexpected in the same cycle: two failures, highest code
    set_exp(2'd0, RESP_OK, 32'd7);
    step(); clr_in();
    set_exp(2'd0, RESP_OK, 32'd8);
    set_rsp(RESP_OK, 2'd1, 32'd0);
    step(); clr_in();
    chk("multi_fail_pulse", fail_pulse, 1);
    chk("multi_fail_code", fail_code, 4);
    chk("multi_fail_cnt", fail_cnt, 5);
    chk("multi_outstanding", outstanding, 1);
    set_rsp(RESP_OK, 2'd0, 32'd7);
    step(); clr_in();
    chk("multi_orig_pass", pass_pulse, 1);
    chk("multi_pass_cnt", pass_cnt, 7);
    chk("multi_code_held", fail_code, 4);

    // timeout after 64 cycles, then a late response
    set_exp(2'd1, RESP_OK, 32'd9);
    step(); clr_in();
    repeat (63) step();
    chk("to_not_yet", fail_pulse, 0);
    chk("to_still_pending", outstanding, 1);
    step();
    chk("to_fail_pulse", fail_pulse, 1);
    chk("to_fail_code", fail_code, 5);
    chk("to_fail_cnt", fail_cnt, 6);
    chk("to_outstanding", outstanding, 0);
    chk("to_idle", idle, 1);
    set_rsp(RESP_OK, 2'd1, 32'd9);
    step(); clr_in();
    chk("late_fail_code", fail_code, 3);
    chk("late_fail_cnt", fail_cnt, 7);

    // same-cycle retire and re-insert on tag 1; pass counter already saturated
    set_exp(2'd1, RESP_OK, 32'h21);
    step(); clr_in();
    set_rsp(RESP_OK, 2'd1, 32'h21);
    set_exp(2'd1, RESP_OK, 32'h22);
    step(); clr_in();
    chk("sc_pass_pulse", pass_pulse, 1);
    chk("sc_no_fail", fail_pulse, 0);
    chk("sc_pass_sat", pass_cnt, 7);
    chk("sc_outstanding", outstanding, 1);

    // reset mid-flight
    reset_n = 1'b0;
    #2;
    chk("mid_rst_outstanding", outstanding, 0);
    chk("mid_rst_idle", idle, 1);
    chk("mid_rst_pass_cnt", pass_cnt, 0);
    chk("mid_rst_fail_cnt", fail_cnt, 0);
    chk("mid_rst_fail_code", fail_code, 0);
    reset_n = 1'b1;
    step();
    set_rsp(RESP_OK, 2'd1, 32'h22);
    step(); clr_in();
    chk("post_rst_code", fail_code, 3);
    chk("post_rst_fail_cnt", fail_cnt, 1);
    chk("post_rst_pass_cnt", pass_cnt, 0);

    // response and expectation together on an empty slot: unexpected, expectation kept
    set_rsp(RESP_OK, 2'd2, 32'd5);
    set_exp(2'd2, RESP_OK, 32'd5);
    step(); clr_in();
    chk("nomatch_pulse", fail_pulse, 1);
    chk("nomatch_code", fail_code, 3);
    chk("nomatch_fail_cnt", fail_cnt, 2);
    chk("nomatch_no_pass", pass_pulse, 0);
    chk("nomatch_stored", outstanding, 1);
    set_rsp(RESP_OK, 2'd2, 32'd5);
    step(); clr_in();
    chk("stored_pass", pass_pulse, 1);
    chk("stored_pass_cnt", pass_cnt, 1);
    chk("stored_idle", idle, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_port_scoreboard.md
CALC_PORT_SCOREBOARD -- requirements
Module: calc_port_scoreboard

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL set the maximum number of cycles an expected entry may wait for its DUT response.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the pass and fail counters.
REQ-003 Clock and reset SHALL be: c_clk, input, 1, single clock (all logic on rising edge); reset_n, input, 1, asynchronous active-low reset.
REQ-004 Port exp_valid, input, 1, SHALL mean that a golden expectation is present this cycle.
REQ-005 Port exp_packet, input, 37, SHALL carry the golden result {tag[36:35], resp[34:33], result[32:1], flag[0]}.
REQ-006 Ports out_resp, out_tag and out_data (input, widths 2, 2 and 32) SHALL carry the DUT port response; out_resp != 0 marks a valid response for exactly one cycle.
REQ-007 Port pass_pulse, output, 1, SHALL pulse for one cycle on a matched response.
REQ-008 Port fail_pulse, output, 1, SHALL pulse for one cycle on any error.
REQ-009 Port fail_code, output, 3, SHALL carry the cause of the most recent failure: 0 none, 1 resp mismatch, 2 data mismatch, 3 unexpected, 4 duplicate tag, 5 timeout.
REQ-010 Ports pass_cnt and fail_cnt, outputs, CNT_W each, SHALL be saturating event counters.
REQ-011 Port outstanding, output, 3, SHALL give the number of valid entries (0..4).
REQ-012 Port idle, output, 1, SHALL be high when outstanding == 0.

Function
REQ-013 The scoreboard SHALL hold 4 entries indexed by tag; each entry holds a valid bit, the expected resp, the expected result and an age counter.
REQ-014 When exp_valid is high and exp_packet.resp == 0, the expectation SHALL be ignored.
REQ-015 When exp_valid is high, resp != 0 and the entry is not valid, the entry SHALL be written valid with age 0 on the next edge.
REQ-016 When exp_valid targets an already-valid entry (not retired in the same cycle), the old entry SHALL be kept and the block SHALL raise fail_pulse with code 4.
REQ-017 When out_resp != 0 and entry[out_tag] is invalid, the block SHALL raise fail_pulse with code 3.
REQ-018 When out_resp != 0 and the entry is valid, the entry SHALL be retired, and the response SHALL be compared as follows:
- out_resp differs from the expected resp: code 1.
- Expected resp == 1 and out_data differs from the expected result: code 2.
- Expected resp == 2: out_data is ignored.
- Otherwise: pass_pulse.
REQ-019 Response and expectation for the same tag in the same cycle:
- The response SHALL first be checked against the existing entry.
- The new expectation SHALL then occupy the freed slot, with no duplicate error.
- A response SHALL never match an expectation arriving in the same cycle; that case is code 3, and the expectation is still stored.
REQ-020 Each valid entry's age SHALL increment every cycle; when age reaches TIMEOUT-1 without a response, the entry SHALL be freed and fail_pulse raised with code 5.
REQ-021 When several failures occur in one cycle, fail_pulse SHALL be high once, fail_cnt SHALL increment by the number of failures (saturating), and fail_code SHALL report the highest code.
REQ-022 Pulses and fail_code SHALL be registered, with 1-cycle latency from the triggering input edge.
REQ-023 Counters SHALL stop at all-ones and never wrap.
REQ-024 outstanding SHALL reflect the entry state after the current edge's inserts, retires and timeouts.

Reset
REQ-025 Asserting reset_n low SHALL immediately clear all valid bits, ages, pass_pulse, fail_pulse, fail_code (to 0), pass_cnt and fail_cnt, and SHALL set outstanding to 0 and idle to 1.
REQ-026 Reset asserted mid-transaction SHALL discard pending entries, and a late DUT response after release SHALL report code 3.

Structure
REQ-027 Shared package calc_pkg SHALL hold:
- the resp constants RESP_NONE=0, RESP_OK=1, RESP_ERR=2;
- the cmd constants ADD=1, SUB=2, SHL=5, SHR=6;
- the exp_packet field positions;
- the fail_code enum.
REQ-028 One slot sub-module, calc_sb_entry, SHALL hold valid, expectation and age with timeout detect, instantiated 4 times.

Verification
REQ-029 The bench SHALL cover each of the following scenarios:
- Expectation {tag 1, resp 1, result 0000_0003} followed 5 cycles later by DUT {resp 1, tag 1, data 3}: pass_pulse, pass_cnt = 1, outstanding back to 0.
- Expectation tag 2 resp 1 result 0000_0010, DUT data 0000_0011: fail_code 2, fail_cnt 1.
- Expectation tag 0 resp 2 (SUB underflow), DUT resp 2 data FFFF_FFFF: pass.
- Expectations for tags 0..3 (outstanding 4), then a second expectation for tag 3: fail_code 4, and the original tag-3 entry still matches later.
- Expectation tag 1 with no response for 64 cycles: fail_code 5 at cycle 64, outstanding 0; a late response then gives code 3.
- Same-cycle DUT response tag 1 plus new expectation tag 1 with a pending entry: pass, outstanding stays 1; reset_n pulsed low mid-flight clears outstanding to 0.
